nested_vic: RTL and testbench
=============================

Name: nested_vic

Overview:
- Parametrised successor to the team's 16-channel VIC: programmable per-channel priority, per-channel edge/level trigger, and nested preemption via an in-service priority stack.
- Sits beside the soft processor on its port bus (cs/port_id/strobes).
- Drives a single InterruptOut/IntAck handshake.
- The processor reads the winning vector address, then writes EOI to unwind one nesting level.

Parameters:
- N_IRQ, 16, interrupt channel count (1..32).
- DW, 16, data bus and vector width.
- PRIO_W, 3, priority field width; larger value = higher priority.
- NEST_DEPTH, 4, maximum number of simultaneously in-service (nested) interrupts.
- PORT_W, 7, port_id width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- cs  in  1  chip select for port accesses.
- datain  in  DW  write data.
- port_id  in  PORT_W  register address.
- read_strobe  in  1  read qualifier; only side effect is on STATUS.ERR.
- write_strobe  in  1  write qualifier; a write occurs on any cycle with cs & write_strobe.
- dout  out  DW  registered read data.
- interrupts  in  N_IRQ  raw interrupt request lines.
- IntAck  in  1  acknowledge; single-cycle pulse.
- InterruptOut  out  1  interrupt request to the processor.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst. When rst=0 at a clk edge, the following are all cleared to 0: all registers, pending, in-service bits, stack, dout, InterruptOut.
- Register map (offsets):
  - 0x00 ENABLE (RW).
  - 0x01 MODE (RW; 1=edge, 0=level).
  - 0x02 PENDING (R; write-1-to-clear, edge channels only).
  - 0x03 STATUS (R: [2:0] stack depth, [3] ERR, [4] stack full). Reading STATUS with read_strobe clears ERR.
  - 0x04 EOI (W; data ignored).
  - 0x06 CUR_VECTOR (R).
  - 0x07 CUR_ID (R).
  - 0x20+i VECTOR[i] (RW, DW bits).
  - 0x40+i PRIO[i] (RW, PRIO_W bits, zero-extended on read).
  - Unmapped or i>=N_IRQ: reads return 0, writes are ignored.
- Read timing: dout registers mux(port_id) every cycle while cs=1 (1-cycle latency); dout holds its value while cs=0.
- Pending:
  - Edge channel: set on a 0->1 transition of interrupts[i] (one-cycle delayed compare).
  - Level channel: pending = interrupts[i] sampled each cycle.
  - Same-cycle set and clear (by W1C or by ack): set wins.
- Eligibility: a channel is eligible when pending & ENABLE & ~in_service & (stack empty | PRIO[i] > top-of-stack priority) & stack not full.
- Arbitration: highest PRIO wins; a tie goes to the lowest index.
- InterruptOut:
  - Registered; asserted the cycle after any channel becomes eligible.
  - Deasserted the cycle after IntAck.
  - Re-evaluated from the next cycle.
- IntAck while InterruptOut=1, processed in that cycle:
  - Latch the winner as {id, PRIO, VECTOR} and push it onto the stack.
  - Set in_service[id].
  - Clear pending[id] if the channel is edge-triggered.
  - CUR_VECTOR/CUR_ID then reflect the new top of stack.
- IntAck while InterruptOut=0: ignored.
- EOI: pop the stack and clear in_service of the popped id; CUR_* fall back to the new top, or 0 when the stack is empty.
  - EOI on an empty stack: no-op; sets ERR.
- Stack full (depth == NEST_DEPTH): no channel is eligible; InterruptOut stays low until an EOI.
- Same-cycle IntAck and EOI: apply the pop first, then the push (net depth unchanged).
- Disabling a channel while it is in service does not affect its stack entry.
- Changing PRIO of an in-service channel does not alter the priority already stored in its stack entry.
- Level channel still asserted at EOI: becomes pending/eligible again immediately.

Decomposition:
- Package nvic_pkg holds:
  - Register offset localparams.
  - STATUS bit positions.
  - A stack-entry struct {id, prio, vector}.
- Sub-module nvic_prio_arbiter: combinational N_IRQ-way max-priority select with lowest-index tie-break. Outputs: valid, id, prio.
- Top level holds the register file, edge detect, stack and handshake.

Test Plan:
- Setup: VECTOR[i]=100+i, PRIO[i]=1, MODE=0xFFFF, ENABLE=0xFFFF. Stimulus: pulse interrupts[3]. Required: InterruptOut rises 2 cycles after the edge; after IntAck, CUR_VECTOR reads 0x0067 and STATUS depth=1; after EOI, depth=0.
- Tie: interrupts[5] and [2] set in the same cycle, both PRIO=1. Required: first ack yields CUR_ID=2; InterruptOut does not re-assert until EOI, since [5] has equal priority; after EOI, the ack yields CUR_ID=5.
- Nesting: PRIO[1]=1 acked, then interrupts[7] with PRIO[7]=4. Required: InterruptOut re-asserts; ack gives depth=2, CUR_VECTOR=0x006B; EOI returns CUR_VECTOR=0x0065.
- Stack full: NEST_DEPTH=4 with ascending priorities 1..5 on five channels. Required: 4 acks accepted and STATUS.full=1; the fifth channel does not raise InterruptOut until an EOI.
- Error: EOI with an empty stack. Required: STATUS reads 0x0008; a second STATUS read returns 0x0000.
- Level channel and W1C: level channel 9 is held high through its EOI. Required: InterruptOut re-asserts. Also, a W1C write to PENDING in the same cycle as a new edge on channel 4 leaves PENDING[4]=1.
- Reset: assert rst=0 mid-nesting at depth 2. Required: next cycle, all outputs and registers read 0.

Source files
------------

// File: rtl/nvic_pkg.sv
// Shared definitions for the nested vectored interrupt controller:
// register offsets, STATUS bit positions and the in-service stack entry.
package nvic_pkg;

  localparam int ID_W       = 5;
  localparam int MAX_PRIO_W = 8;
  localparam int MAX_DW     = 32;

  localparam logic [7:0] REG_ENABLE      = 8'h00;
  localparam logic [7:0] REG_MODE        = 8'h01;
  localparam logic [7:0] REG_PENDING     = 8'h02;
  localparam logic [7:0] REG_STATUS      = 8'h03;
  localparam logic [7:0] REG_EOI         = 8'h04;
  localparam logic [7:0] REG_CUR_VECTOR  = 8'h06;
  localparam logic [7:0] REG_CUR_ID      = 8'h07;
  localparam logic [7:0] REG_VECTOR_BASE = 8'h20;
  localparam logic [7:0] REG_PRIO_BASE   = 8'h40;

  localparam int ST_DEPTH_W  = 3;
  localparam int ST_ERR_BIT  = 3;
  localparam int ST_FULL_BIT = 4;

  // Fields are sized for the largest legal configuration; narrower
  // instances zero-extend into them.
  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [MAX_PRIO_W-1:0] prio;
    logic [MAX_DW-1:0]     vector;
  } stack_entry_t;

endpackage

// File: rtl/nvic_prio_arbiter.sv
// Combinational max-priority select across all request lines; equal
// priorities resolve to the lowest channel index.
module nvic_prio_arbiter
  import nvic_pkg::*;
#(
  parameter int N_IRQ  = 16,
  parameter int PRIO_W = 3
) (
  input  logic [N_IRQ-1:0]        req,
  input  logic [N_IRQ*PRIO_W-1:0] prio_flat,
  output logic                    valid,
  output logic [ID_W-1:0]         id,
  output logic [PRIO_W-1:0]       prio
);

  // Scan upward; strict greater-than keeps the earliest index on a tie.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    prio  = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (req[i] && (!valid || (prio_flat[i*PRIO_W +: PRIO_W] > prio))) begin
        valid = 1'b1;
        id    = ID_W'(i);
        prio  = prio_flat[i*PRIO_W +: PRIO_W];
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/nested_vic.sv
// Nested vectored interrupt controller: port-bus register file, edge/level
// pending logic, in-service priority stack and InterruptOut/IntAck handshake.
module nested_vic
  import nvic_pkg::*;
#(
  parameter int N_IRQ      = 16,
  parameter int DW         = 16,
  parameter int PRIO_W     = 3,
  parameter int NEST_DEPTH = 4,
  parameter int PORT_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [DW-1:0]     datain,
  input  logic [PORT_W-1:0] port_id,
  input  logic              read_strobe,
  input  logic              write_strobe,
  output logic [DW-1:0]     dout,
  input  logic [N_IRQ-1:0]  interrupts,
  input  logic              IntAck,
  output logic              InterruptOut
);

  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

  logic [N_IRQ-1:0]   enable_r, mode_r, pend_r, in_service_r, irq_d_r;
  logic [DW-1:0]      vector_r [N_IRQ];
  logic [PRIO_W-1:0]  prio_r [N_IRQ];
  stack_entry_t       stack_r [NEST_DEPTH];
  logic [DEPTH_W-1:0] depth_r;
  logic               err_r, int_out_r;
  logic [DW-1:0]      dout_r;

  logic [7:0]              addr_s;
  logic                    wr_s, eoi_s, status_rd_s, ack_s, pop_s, push_s;
  logic                    empty_s, full_s;
  logic [DEPTH_W-1:0]      depth_pop_s;
  stack_entry_t            top_s, new_entry_s;
  logic [N_IRQ-1:0]        elig_s, rise_s, w1c_clr_s, ack_clr_s, pop_clr_s, push_set_s;
  logic [N_IRQ*PRIO_W-1:0] prio_flat_s;
  logic                    win_valid_s;
  logic [ID_W-1:0]         win_id_s;
  logic [PRIO_W-1:0]       win_prio_s;
  logic [DW-1:0]           rd_data_s, status_s;

  function automatic logic [N_IRQ-1:0] to_irq(input logic [DW-1:0] d);
    logic [N_IRQ-1:0] r;
    r = '0;
    for (int i = 0; i < N_IRQ; i++) r[i] = (i < DW) ? d[i % DW] : 1'b0;
    return r;
  endfunction

  function automatic logic [DW-1:0] to_dw(input logic [N_IRQ-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) r[i] = (i < N_IRQ) ? v[i % N_IRQ] : 1'b0;
    return r;
  endfunction

  function automatic logic [N_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_IRQ-1:0] r;
    r = '0;
    for (int i = 0; i < N_IRQ; i++) r[i] = (id == ID_W'(i));
    return r;
  endfunction

  assign addr_s      = 8'(port_id);
  assign wr_s        = cs & write_strobe;
  assign eoi_s       = wr_s & (addr_s == REG_EOI);
  assign status_rd_s = cs & read_strobe & (addr_s == REG_STATUS);
  assign ack_s       = IntAck & int_out_r;
  assign empty_s     = (depth_r == '0);
  assign full_s      = (depth_r == DEPTH_W'(NEST_DEPTH));
  assign pop_s       = eoi_s & ~empty_s;
  assign push_s      = ack_s & win_valid_s;
  assign depth_pop_s = depth_r - DEPTH_W'(pop_s);
  assign rise_s      = interrupts & ~irq_d_r;
  assign w1c_clr_s   = (wr_s && (addr_s == REG_PENDING)) ? to_irq(datain) : '0;
  assign ack_clr_s   = push_s ? (onehot(win_id_s) & mode_r) : '0;
  assign pop_clr_s   = pop_s ? onehot(top_s.id) : '0;
  assign push_set_s  = push_s ? onehot(win_id_s) : '0;

  // Top-of-stack entry, all zeros when nothing is in service.
  always_comb begin
    top_s = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (DEPTH_W'(i + 1) == depth_r) top_s = stack_r[i];
      else                            top_s = top_s;
    end
  end

  // Eligibility: preemption only by a strictly higher priority than the top.
  always_comb begin
    elig_s      = '0;
    prio_flat_s = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      prio_flat_s[i*PRIO_W +: PRIO_W] = prio_r[i];
      elig_s[i] = pend_r[i] & enable_r[i] & ~in_service_r[i] & ~full_s &
                  (empty_s | (MAX_PRIO_W'(prio_r[i]) > top_s.prio));
    end
  end

  nvic_prio_arbiter #(
    .N_IRQ  (N_IRQ),
    .PRIO_W (PRIO_W)
  ) u_arb (
    .req       (elig_s),
    .prio_flat (prio_flat_s),
    .valid     (win_valid_s),
    .id        (win_id_s),
    .prio      (win_prio_s)
  );

  // Stack entry captured for the current winner at acknowledge time.
  always_comb begin
    new_entry_s      = '0;
    new_entry_s.id   = win_id_s;
    new_entry_s.prio = MAX_PRIO_W'(win_prio_s);
    for (int i = 0; i < N_IRQ; i++) begin
      if (win_id_s == ID_W'(i)) new_entry_s.vector = MAX_DW'(vector_r[i]);
      else                      new_entry_s.vector = new_entry_s.vector;
    end
  end

  // Read data mux, including the banked VECTOR/PRIO windows.
  always_comb begin
    status_s                        = '0;
    status_s[ST_DEPTH_W-1:0]        = ST_DEPTH_W'(depth_r);
    status_s[ST_ERR_BIT]            = err_r;
    status_s[ST_FULL_BIT]           = full_s;
    rd_data_s = '0;
    case (addr_s)
      REG_ENABLE:     rd_data_s = to_dw(enable_r);
      REG_MODE:       rd_data_s = to_dw(mode_r);
      REG_PENDING:    rd_data_s = to_dw(pend_r);
      REG_STATUS:     rd_data_s = status_s;
      REG_CUR_VECTOR: rd_data_s = DW'(top_s.vector);
      REG_CUR_ID:     rd_data_s = DW'(top_s.id);
      default: begin
        for (int i = 0; i < N_IRQ; i++) begin
          if (addr_s == REG_VECTOR_BASE + 8'(i))    rd_data_s = vector_r[i];
          else if (addr_s == REG_PRIO_BASE + 8'(i)) rd_data_s = DW'(prio_r[i]);
          else                                      rd_data_s = rd_data_s;
        end
      end
    endcase
  end

  // All controller state; an EOI pop is applied before a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      enable_r     <= '0;
      mode_r       <= '0;
      pend_r       <= '0;
      in_service_r <= '0;
      irq_d_r      <= '0;
      depth_r      <= '0;
      err_r        <= 1'b0;
      int_out_r    <= 1'b0;
      dout_r       <= '0;
      for (int i = 0; i < N_IRQ; i++) begin
        vector_r[i] <= '0;
        prio_r[i]   <= '0;
      end
      for (int i = 0; i < NEST_DEPTH; i++) stack_r[i] <= '0;
    end else begin
      irq_d_r      <= interrupts;
      pend_r       <= (mode_r & ((pend_r & ~(w1c_clr_s | ack_clr_s)) | rise_s)) |
                      (~mode_r & interrupts);
      in_service_r <= (in_service_r & ~pop_clr_s) | push_set_s;
      depth_r      <= depth_pop_s + DEPTH_W'(push_s);
      int_out_r    <= ack_s ? 1'b0 : |elig_s;
      if (cs) dout_r <= rd_data_s;
      if (eoi_s && empty_s) err_r <= 1'b1;
      else if (status_rd_s) err_r <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (push_s && (DEPTH_W'(i) == depth_pop_s)) stack_r[i] <= new_entry_s;
      end
      if (wr_s) begin
        case (addr_s)
          REG_ENABLE: enable_r <= to_irq(datain);
          REG_MODE:   mode_r   <= to_irq(datain);
          default: begin
            for (int i = 0; i < N_IRQ; i++) begin
              if (addr_s == REG_VECTOR_BASE + 8'(i))    vector_r[i] <= datain;
              else if (addr_s == REG_PRIO_BASE + 8'(i)) prio_r[i]   <= datain[PRIO_W-1:0];
            end
          end
        endcase
      end
    end
  end

  assign dout         = dout_r;
  assign InterruptOut = int_out_r;

endmodule

// File: tb/tb_nested_vic.sv
// Bench for nested_vic: a queue-based reference of the controller checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_nested_vic;

  logic        clk = 1'b0;
  logic        rst, cs, read_strobe, write_strobe, IntAck, InterruptOut;
  logic [15:0] datain, dout, interrupts;
  logic [6:0]  port_id;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  nested_vic dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .datain       (datain),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .dout         (dout),
    .interrupts   (interrupts),
    .IntAck       (IntAck),
    .InterruptOut (InterruptOut)
  );

  always #5 clk = ~clk;

  // Reference model state: registers as arrays, the in-service stack as queues.
  bit [15:0] m_en, m_mode, m_pend, m_isv, m_prev, m_dout;
  bit [15:0] m_vec [16];
  bit [2:0]  m_prio [16];
  bit        m_err, m_out;
  int        st_id [$];
  int        st_pr [$];
  bit [15:0] st_vec [$];

  function automatic int winner();
    int best = -1;
    for (int c = 0; c < 16; c++) begin
      bit ok = m_pend[c] && m_en[c] && !m_isv[c] && (st_id.size() < 4) &&
               (st_id.size() == 0 || int'(m_prio[c]) > st_pr[st_pr.size()-1]);
      if (ok && (best < 0 || m_prio[c] > m_prio[best])) best = c;
    end
    return best;
  endfunction

  function automatic bit [15:0] m_read(int p);
    int d = st_id.size();
    if (p == 0) return m_en;
    if (p == 1) return m_mode;
    if (p == 2) return m_pend;
    if (p == 3) return 16'(d) | (m_err ? 16'h0008 : 16'h0000) | (d == 4 ? 16'h0010 : 16'h0000);
    if (p == 6) return (d == 0) ? 16'h0000 : st_vec[d-1];
    if (p == 7) return (d == 0) ? 16'h0000 : 16'(st_id[d-1]);
    if (p >= 32 && p < 48) return m_vec[p-32];
    if (p >= 64 && p < 80) return 16'(m_prio[p-64]);
    return 16'h0000;
  endfunction

  task automatic model_step();
    int w, p;
    bit ack, wr;
    bit [15:0] clr, np;
    if (!rst) begin
      m_en = 0; m_mode = 0; m_pend = 0; m_isv = 0; m_prev = 0; m_dout = 0;
      m_err = 0; m_out = 0;
      for (int i = 0; i < 16; i++) begin m_vec[i] = 0; m_prio[i] = 0; end
      st_id.delete(); st_pr.delete(); st_vec.delete();
      return;
    end
    w   = winner();
    ack = IntAck && m_out;
    p   = int'(port_id);
    wr  = cs && write_strobe;
    if (cs) m_dout = m_read(p);
    clr = (wr && p == 2) ? datain : 16'h0000;
    if (ack && w >= 0 && m_mode[w]) clr[w] = 1'b1;
    for (int c = 0; c < 16; c++)
      np[c] = m_mode[c] ? ((m_pend[c] && !clr[c]) || (interrupts[c] && !m_prev[c])) : interrupts[c];
    if (cs && read_strobe && p == 3) m_err = 0;
    if (wr && p == 4) begin
      if (st_id.size() == 0) m_err = 1;
      else begin
        m_isv[st_id[st_id.size()-1]] = 0;
        void'(st_id.pop_back()); void'(st_pr.pop_back()); void'(st_vec.pop_back());
      end
    end
    if (ack && w >= 0) begin
      st_id.push_back(w); st_pr.push_back(int'(m_prio[w])); st_vec.push_back(m_vec[w]);
      m_isv[w] = 1;
    end
    m_out = ack ? 1'b0 : (w >= 0);
    if (wr) begin
      if (p == 0) m_en = datain;
      else if (p == 1) m_mode = datain;
      else if (p >= 32 && p < 48) m_vec[p-32] = datain;
      else if (p >= 64 && p < 80) m_prio[p-64] = datain[2:0];
    end
    m_pend = np;
    m_prev = interrupts;
  endtask

  always @(posedge clk) model_step();

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("int_out", {15'd0, InterruptOut}, {15'd0, m_out});
      check("dout", dout, m_dout);
    end
  end

  task automatic cyc(int n); repeat (n) @(negedge clk); endtask

  task automatic wr(int a, logic [15:0] d);
    cs = 1'b1; write_strobe = 1'b1; port_id = 7'(a); datain = d;
    cyc(1);
    cs = 1'b0; write_strobe = 1'b0;
  endtask

  task automatic rd(int a);
    cs = 1'b1; read_strobe = 1'b1; port_id = 7'(a);
    cyc(1);
    cs = 1'b0; read_strobe = 1'b0;
  endtask

  task automatic ack(); IntAck = 1'b1; cyc(1); IntAck = 1'b0; endtask
  task automatic eoi(); wr(4, 16'h0000); endtask
  task automatic pulse(int ch); interrupts[ch] = 1'b1; cyc(1); interrupts[ch] = 1'b0; endtask

  task automatic wait_out(string name);
    for (int k = 0; k < 10 && !InterruptOut; k++) cyc(1);
    check(name, {15'd0, InterruptOut}, 16'h0001);
  endtask

  initial begin
    rst = 1'b0; cs = 1'b0; read_strobe = 1'b0; write_strobe = 1'b0; IntAck = 1'b0;
    datain = 16'h0000; port_id = 7'h00; interrupts = 16'h0000;
    cyc(2);
    chk_en = 1'b1;
    check("reset_dout", dout, 16'h0000);
    check("reset_out", {15'd0, InterruptOut}, 16'h0000);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin wr(32 + i, 16'(100 + i)); wr(64 + i, 16'h0001); end
    wr(1, 16'hFFFF); wr(0, 16'hFFFF);

    // Basic: InterruptOut two cycles after the edge, vector 100+3.
    interrupts[3] = 1'b1; cyc(1); interrupts[3] = 1'b0;
    check("out_early", {15'd0, InterruptOut}, 16'h0000);
    cyc(1);
    check("out_2cyc", {15'd0, InterruptOut}, 16'h0001);
    ack();
    rd(6); check("basic_vec", dout, 16'h0067);
    rd(3); check("basic_depth1", dout, 16'h0001);
    eoi();
    rd(3); check("basic_depth0", dout, 16'h0000);

    // Tie between channels 5 and 2 at equal priority.
    interrupts[5] = 1'b1; interrupts[2] = 1'b1; cyc(1); interrupts = 16'h0000;
    wait_out("tie_out");
    ack();
    rd(7); check("tie_id2", dout, 16'h0002);
    cyc(3);
    check("tie_no_preempt", {15'd0, InterruptOut}, 16'h0000);
    eoi();
    wait_out("tie_out2");
    ack();
    rd(7); check("tie_id5", dout, 16'h0005);
    eoi();

    // Nesting: channel 7 at priority 4 preempts channel 1.
    wr(64 + 7, 16'h0004);
    pulse(1); wait_out("nest_out1"); ack();
    pulse(7); wait_out("nest_out2"); ack();
    rd(3); check("nest_depth2", dout, 16'h0002);
    rd(6); check("nest_vec7", dout, 16'h006B);
    eoi();
    rd(6); check("nest_vec1", dout, 16'h0065);
    eoi();

    // Stack full with ascending priorities 1..5 on channels 10..14.
    for (int k = 0; k < 5; k++) wr(64 + 10 + k, 16'(k + 1));
    for (int k = 0; k < 4; k++) begin pulse(10 + k); wait_out("full_fill"); ack(); end
    rd(3); check("full_status", dout, 16'h0014);
    pulse(14); cyc(4);
    check("full_blocked", {15'd0, InterruptOut}, 16'h0000);
    eoi();
    wait_out("full_after_eoi");
    ack();
    rd(7); check("full_id14", dout, 16'h000E);
    repeat (4) eoi();
    rd(3); check("full_unwound", dout, 16'h0000);

    // EOI with nothing in service.
    eoi();
    rd(3); check("err_set", dout, 16'h0008);
    rd(3); check("err_clear", dout, 16'h0000);

    // Level channel 9 held high across its EOI.
    wr(1, 16'hFDFF);
    interrupts[9] = 1'b1;
    wait_out("level_out"); ack();
    rd(7); check("level_id9", dout, 16'h0009);
    eoi();
    wait_out("level_reassert"); ack();
    interrupts[9] = 1'b0;
    eoi();
    wr(1, 16'hFFFF);

    // W1C racing a new edge on channel 4: the set wins.
    wr(0, 16'hFFEF);
    cs = 1'b1; write_strobe = 1'b1; port_id = 7'h02; datain = 16'h0010; interrupts[4] = 1'b1;
    cyc(1);
    cs = 1'b0; write_strobe = 1'b0; interrupts[4] = 1'b0;
    rd(2); check("w1c_set_wins", dout, 16'h0010);
    wr(2, 16'h0010);
    rd(2); check("w1c_clears", dout, 16'h0000);
    wr(0, 16'hFFFF);

    // Reset in the middle of a two-deep nest.
    pulse(1); wait_out("rst_out1"); ack();
    pulse(7); wait_out("rst_out2"); ack();
    rd(3); check("rst_depth2", dout, 16'h0002);
    rst = 1'b0; cyc(1);
    check("rst_out", {15'd0, InterruptOut}, 16'h0000);
    check("rst_dout", dout, 16'h0000);
    rst = 1'b1;
    rd(3);  check("rst_status", dout, 16'h0000);
    rd(0);  check("rst_enable", dout, 16'h0000);
    rd(39); check("rst_vector", dout, 16'h0000);
    rd(71); check("rst_prio", dout, 16'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 16; i++) begin
      wr(32 + i, 16'($urandom));
      wr(64 + i, 16'($urandom_range(0, 7)));
    end
    wr(1, 16'($urandom)); wr(0, 16'($urandom) | 16'h0F0F);
    for (int n = 0; n < 3000; n++) begin
      int r;
      IntAck = 1'b0; cs = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0;
      datain = 16'($urandom); port_id = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 5) == 0) interrupts[$urandom_range(0, 15)] ^= 1'b1;
      r = $urandom_range(0, 99);
      if (m_out && r < 30) IntAck = 1'b1;
      else if (r < 33) IntAck = 1'b1;
      else if (r < 43) begin cs = 1'b1; write_strobe = 1'b1; port_id = 7'h04; end
      else if (r < 50) begin cs = 1'b1; read_strobe = 1'b1; port_id = 7'h03; end
      else if (r < 55) begin cs = 1'b1; write_strobe = 1'b1; port_id = 7'h02; end
      else if (r < 58) begin cs = 1'b1; write_strobe = 1'b1; port_id = 7'(64 + $urandom_range(0, 15)); end
      else if (r < 60) begin cs = 1'b1; write_strobe = 1'b1; port_id = 7'h00; end
      else if (r < 62) begin cs = 1'b1; write_strobe = 1'b1; port_id = 7'h01; end
      else if (r < 64) begin cs = 1'b1; write_strobe = 1'b1; port_id = 7'(32 + $urandom_range(0, 15)); end
      else if (r < 85) begin cs = 1'b1; read_strobe = 1'($urandom_range(0, 1)); end
      cyc(1);
    end
    IntAck = 1'b0; cs = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
